core_lsu: RTL

Data-memory load/store unit: an AXI4-Lite master that performs the single data access requested by the core control FSM while it sits in its memory stage. It turns the latched memory controls (C_DOLOAD / C_DOSTORE, DMEM_ADDR, STRB, ISLOADBS, ISLOADHWS) into one AXI read or write. It exposes the RVALID/RREADY and BVALID/BREADY pairs that the control FSM uses to leave its memory stage. It also returns lane-extracted, sign- or zero-extended load data for the following write-back cycle.

---
 rtl/core_lsu_pkg.sv | 39 +++
 rtl/core_lsu_if.sv | 59 +++++
 rtl/core_lsu_align.sv | 54 +++++
 rtl/core_lsu.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/core_lsu_pkg.sv
// core_lsu_pkg
//   Shared types and constants for the data-memory load/store unit:
//   - lsu_state_e     : FSM state encodings (also exported on the debug port)
//   - AXI_RESP_*      : AXI response codes
//   - lsu_size_e      : access size derived from the byte-enable popcount
//   - size_from_strb  : popcount(STRB) -> access size (1 byte, 2 half, else word)
package core_lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AWW  = 3'd3,
        S_B    = 3'd4,
        S_REL  = 3'd5
    } lsu_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    // STRB is already lane-shifted, so only the number of set bits tells
    // the size; zero or any other count is treated as a word access.
    function automatic lsu_size_e size_from_strb(input logic [3:0] strb);
        logic [2:0] n;
        n = 3'(strb[0]) + 3'(strb[1]) + 3'(strb[2]) + 3'(strb[3]);
        case (n)
            3'd1:    return SZ_BYTE;
            3'd2:    return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/core_lsu_if.sv
// core_lsu_if
//   AXI4-Lite bus between the load/store unit (master) and data memory (slave).
//   Parameter ADDR_W: address width; data width is fixed at 32.
//
//   Handshake rule for every channel: a transfer happens on a rising CLK edge
//   where VALID and READY are both high. Once VALID is raised, it and its
//   payload stay unchanged until that edge; READY may change freely.
interface core_lsu_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] HOST_AXI_ARADDR;
    logic              HOST_AXI_ARVALID;
    logic              HOST_AXI_ARREADY;

    logic [31:0]       HOST_AXI_RDATA;
    logic [1:0]        HOST_AXI_RRESP;
    logic              HOST_AXI_RVALID;
    logic              HOST_AXI_RREADY;

    logic [ADDR_W-1:0] HOST_AXI_AWADDR;
    logic              HOST_AXI_AWVALID;
    logic              HOST_AXI_AWREADY;

    logic [31:0]       HOST_AXI_WDATA;
    logic [3:0]        HOST_AXI_WSTRB;
    logic              HOST_AXI_WVALID;
    logic              HOST_AXI_WREADY;

    logic [1:0]        HOST_AXI_BRESP;
    logic              HOST_AXI_BVALID;
    logic              HOST_AXI_BREADY;

    modport master (
        output HOST_AXI_ARADDR, HOST_AXI_ARVALID,
        input  HOST_AXI_ARREADY,
        input  HOST_AXI_RDATA, HOST_AXI_RRESP, HOST_AXI_RVALID,
        output HOST_AXI_RREADY,
        output HOST_AXI_AWADDR, HOST_AXI_AWVALID,
        input  HOST_AXI_AWREADY,
        output HOST_AXI_WDATA, HOST_AXI_WSTRB, HOST_AXI_WVALID,
        input  HOST_AXI_WREADY,
        input  HOST_AXI_BRESP, HOST_AXI_BVALID,
        output HOST_AXI_BREADY
    );

    modport slave (
        input  HOST_AXI_ARADDR, HOST_AXI_ARVALID,
        output HOST_AXI_ARREADY,
        output HOST_AXI_RDATA, HOST_AXI_RRESP, HOST_AXI_RVALID,
        input  HOST_AXI_RREADY,
        input  HOST_AXI_AWADDR, HOST_AXI_AWVALID,
        output HOST_AXI_AWREADY,
        input  HOST_AXI_WDATA, HOST_AXI_WSTRB, HOST_AXI_WVALID,
        output HOST_AXI_WREADY,
        output HOST_AXI_BRESP, HOST_AXI_BVALID,
        input  HOST_AXI_BREADY
    );

endinterface

// File: rtl/core_lsu_align.sv
// core_lsu_align
//   Combinational lane handling for the load/store unit.
//   Ports:
//     rdata       in  32  raw AXI read data
//     addr_lo     in  2   byte offset within the word
//     strb        in  4   lane-aligned byte enables (gives access size)
//     is_load_bs  in  1   sign-extend byte loads
//     is_load_hws in  1   sign-extend halfword loads
//     store_data  in  32  unshifted store value
//     load_ext    out 32  extracted, extended load value
//     wdata       out 32  store value moved onto its byte lanes
//     misaligned  out 1   halfword on odd address or word not on a word boundary
module core_lsu_align
    import core_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  strb,
    input  logic        is_load_bs,
    input  logic        is_load_hws,
    input  logic [31:0] store_data,
    output logic [31:0] load_ext,
    output logic [31:0] wdata,
    output logic        misaligned
);

    lsu_size_e   size;
    logic [4:0]  shamt;
    logic [31:0] sh;

    assign size  = size_from_strb(strb);
    assign shamt = {addr_lo, 3'b000};
    assign sh    = rdata >> shamt;
    assign wdata = store_data << shamt;

    always_comb begin
        load_ext   = sh;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                load_ext = {{24{is_load_bs & sh[7]}}, sh[7:0]};
            end
            SZ_HALF: begin
                load_ext   = {{16{is_load_hws & sh[15]}}, sh[15:0]};
                misaligned = addr_lo[0];
            end
            default: begin
                load_ext   = sh;
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// core_lsu
//   Data-memory load/store unit. Turns the memory-stage request of the core
//   control FSM into a single AXI4-Lite read or write and returns the
//   extended load value for write-back.
//   Ports:
//     CLK, NRST            clock, asynchronous active-low reset
//     C_DOLOAD, C_DOSTORE  requests, held by control until R / B handshake
//     DMEM_ADDR            byte address
//     STRB                 lane-aligned byte enables
//     ISLOADBS, ISLOADHWS  signed byte / signed halfword load
//     STORE_DATA           unshifted store value
//     LOAD_DATA            registered, extended load result
//     LSU_BUSY             high whenever the FSM is not idle
//     LSU_ERR              one-cycle pulse after an erroring/misaligned access
//     LSU_STATE            current FSM state (debug)
//     axi                  AXI4-Lite master port
module core_lsu
    import core_lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic        C_DOLOAD,
    input  logic        C_DOSTORE,
    input  logic [31:0] DMEM_ADDR,
    input  logic [3:0]  STRB,
    input  logic        ISLOADBS,
    input  logic        ISLOADHWS,
    input  logic [31:0] STORE_DATA,
    output logic [31:0] LOAD_DATA,
    output logic        LSU_BUSY,
    output logic        LSU_ERR,
    output lsu_state_e  LSU_STATE,
    core_lsu_if.master  axi
);

    lsu_state_e        state_q, state_n;
    logic              aw_done_q, aw_done_n;
    logic              w_done_q, w_done_n;

    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        strb_q;
    logic              bs_q, hws_q;
    logic [31:0]       sdata_q;

    logic              arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic [31:0]       load_q;
    logic              err_q;

    logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic              capture;
    logic [31:0]       load_ext, wdata;
    logic              misaligned;

    assign ar_hs = arvalid_q & axi.HOST_AXI_ARREADY;
    assign r_hs  = rready_q  & axi.HOST_AXI_RVALID;
    assign aw_hs = awvalid_q & axi.HOST_AXI_AWREADY;
    assign w_hs  = wvalid_q  & axi.HOST_AXI_WREADY;
    assign b_hs  = bready_q  & axi.HOST_AXI_BVALID;

    assign capture = (state_q == S_IDLE) & (C_DOLOAD | C_DOSTORE);

    core_lsu_align u_align (
        .rdata       (axi.HOST_AXI_RDATA),
        .addr_lo     (addr_q[1:0]),
        .strb        (strb_q),
        .is_load_bs  (bs_q),
        .is_load_hws (hws_q),
        .store_data  (sdata_q),
        .load_ext    (load_ext),
        .wdata       (wdata),
        .misaligned  (misaligned)
    );

    always_comb begin
        state_n   = state_q;
        aw_done_n = aw_done_q;
        w_done_n  = w_done_q;
        case (state_q)
            S_IDLE: begin
                aw_done_n = 1'b0;
                w_done_n  = 1'b0;
                if (C_DOLOAD) begin
                    state_n = S_AR;
                end else if (C_DOSTORE) begin
                    state_n = S_AWW;
                end
            end
            S_AR: begin
                if (ar_hs) state_n = S_R;
            end
            S_R: begin
                if (r_hs) state_n = S_REL;
            end
            S_AWW: begin
                // Address and data channels complete independently, possibly
                // in the same cycle.
                aw_done_n = aw_done_q | aw_hs;
                w_done_n  = w_done_q  | w_hs;
                if (aw_done_n && w_done_n) state_n = S_B;
            end
            S_B: begin
                if (b_hs) state_n = S_REL;
            end
            S_REL: begin
                // Control still holds its request through the completing
                // cycle; wait for it to drop so the access is not repeated.
                if (!C_DOLOAD && !C_DOSTORE) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // VALID/READY flops are loaded from the next state so each is a clean
    // register output with no combinational path from AXI inputs.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q   <= S_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            load_q    <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            aw_done_q <= aw_done_n;
            w_done_q  <= w_done_n;
            arvalid_q <= (state_n == S_AR);
            rready_q  <= (state_n == S_R);
            awvalid_q <= (state_n == S_AWW) & ~aw_done_n;
            wvalid_q  <= (state_n == S_AWW) & ~w_done_n;
            bready_q  <= (state_n == S_B);
            if (r_hs) load_q <= load_ext;
            // Errors are reported but never abort the access.
            err_q <= (r_hs & ((axi.HOST_AXI_RRESP != AXI_RESP_OKAY) | misaligned)) |
                     (b_hs & ((axi.HOST_AXI_BRESP != AXI_RESP_OKAY) | misaligned));
        end
    end

    // Request fields only change while idle, which keeps AxADDR/WDATA/WSTRB
    // stable for the whole access.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            addr_q  <= '0;
            strb_q  <= 4'h0;
            bs_q    <= 1'b0;
            hws_q   <= 1'b0;
            sdata_q <= 32'h0;
        end else if (capture) begin
            addr_q  <= DMEM_ADDR[ADDR_W-1:0];
            strb_q  <= STRB;
            bs_q    <= ISLOADBS;
            hws_q   <= ISLOADHWS;
            sdata_q <= STORE_DATA;
        end
    end

    assign axi.HOST_AXI_ARADDR  = {addr_q[ADDR_W-1:2], 2'b00};
    assign axi.HOST_AXI_ARVALID = arvalid_q;
    assign axi.HOST_AXI_RREADY  = rready_q;
    assign axi.HOST_AXI_AWADDR  = {addr_q[ADDR_W-1:2], 2'b00};
    assign axi.HOST_AXI_AWVALID = awvalid_q;
    assign axi.HOST_AXI_WDATA   = wdata;
    assign axi.HOST_AXI_WSTRB   = strb_q;
    assign axi.HOST_AXI_WVALID  = wvalid_q;
    assign axi.HOST_AXI_BREADY  = bready_q;

    assign LOAD_DATA = load_q;
    assign LSU_BUSY  = (state_q != S_IDLE);
    assign LSU_ERR   = err_q;
    assign LSU_STATE = state_q;

endmodule
